lsu_mem_master: RTL and testbench

- Load/store initiator between the CPU datapath and a word-wide data memory with a req/ack handshake.
- Accepts one load or store per transaction: word, byte or halfword, with signed or unsigned load extension.
- Handles lane selection and sub-word extension; sub-word stores use read-modify-write because the memory port has no byte enables.
- Sits in the memory stage of the multi-cycle CPU; the data memory is the responder on its mem_* side.

---
 rtl/lsu_mem_master_if.sv | 41 ++++
 rtl/lsu_mem_master.sv | 186 ++++++++++++++++++
 tb/tb_lsu_mem_master.sv | 393 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_master_if.sv
// Bus bundle for lsu_mem_master: CPU request/response side plus the word-wide memory port.
// mem_be is present only when LSU_BYTE_EN is defined.
interface lsu_mem_master_if #(
    parameter int ADDR_W = 12
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-3:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;
`ifdef LSU_BYTE_EN
    logic [3:0]        mem_be;
`endif

    modport master (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_ack, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_req, mem_we, mem_addr, mem_wdata
`ifdef LSU_BYTE_EN
        , output mem_be
`endif
    );

    modport slave (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_ack, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_req, mem_we, mem_addr, mem_wdata
`ifdef LSU_BYTE_EN
        , input mem_be
`endif
    );
endinterface

// File: rtl/lsu_mem_master.sv
// Load/store initiator: one CPU load/store per transaction onto a word-wide req/ack memory.
// Sub-word stores use read-modify-write; define LSU_BYTE_EN to use mem_be lane enables instead.
module lsu_mem_master #(
    parameter int ADDR_W = 12
) (
    input  logic             clk,
    input  logic             reset,
    lsu_mem_master_if.master bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic [1:0] SZ_WORD = 2'd0;
    localparam logic [1:0] SZ_BYTE = 2'd1;
    localparam logic [1:0] SZ_HALF = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              sgn_q, sgn_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [31:0]       wdata_q, wdata_d;
`ifdef LSU_BYTE_EN
    logic [3:0]        be_q, be_d;
`endif
    logic              misaligned;
    logic [31:0]       merge_mask;

    function automatic logic [31:0] lane_mask(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: lane_mask = 32'h0000_00FF << {lo, 3'b000};
            SZ_HALF: lane_mask = lo[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
            default: lane_mask = 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wd);
        case (size)
            SZ_BYTE: lane_data = {4{wd[7:0]}};
            SZ_HALF: lane_data = {2{wd[15:0]}};
            default: lane_data = wd;
        endcase
    endfunction

    // Alignment is guaranteed here, so a half shift is always 0 or 16.
    function automatic logic [31:0] load_extend(input logic [1:0] size, input logic sgn,
                                                input logic [1:0] lo, input logic [31:0] word);
        logic [31:0] sh;
        sh = word >> {lo, 3'b000};
        case (size)
            SZ_BYTE: load_extend = {{24{sgn & sh[7]}}, sh[7:0]};
            SZ_HALF: load_extend = {{16{sgn & sh[15]}}, sh[15:0]};
            default: load_extend = word;
        endcase
    endfunction

`ifdef LSU_BYTE_EN
    function automatic logic [3:0] be_of(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: be_of = 4'b0001 << lo;
            SZ_HALF: be_of = lo[1] ? 4'b1100 : 4'b0011;
            default: be_of = 4'b1111;
        endcase
    endfunction
`endif

    always_comb begin
        case (bus.req_size)
            SZ_WORD: misaligned = |bus.req_addr[1:0];
            SZ_HALF: misaligned = bus.req_addr[0];
            SZ_BYTE: misaligned = 1'b0;
            default: misaligned = 1'b1;
        endcase
    end

    assign merge_mask = lane_mask(size_q, addr_q[1:0]);

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        sgn_d   = sgn_q;
        addr_d  = addr_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        wdata_d = wdata_q;
`ifdef LSU_BYTE_EN
        be_d    = be_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    we_d   = bus.req_we;
                    size_d = bus.req_size;
                    sgn_d  = bus.req_signed;
                    addr_d = bus.req_addr;
                    err_d  = misaligned;
`ifdef LSU_BYTE_EN
                    wdata_d = lane_data(bus.req_size, bus.req_wdata);
                    be_d    = bus.req_we ? be_of(bus.req_size, bus.req_addr[1:0]) : 4'b1111;
`else
                    wdata_d = bus.req_wdata;
`endif
                    if (misaligned) begin
                        rdata_d = '0;
                        state_d = ST_RESP;
                    end else if (!bus.req_we) begin
                        state_d = ST_READ;
                    end else if (bus.req_size == SZ_WORD) begin
                        state_d = ST_WRITE;
                    end else begin
`ifdef LSU_BYTE_EN
                        state_d = ST_WRITE;
`else
                        state_d = ST_READ;
`endif
                    end
                end
            end
            ST_READ: begin
                if (bus.mem_ack) begin
                    if (we_q) begin
                        wdata_d = (bus.mem_rdata & ~merge_mask) |
                                  (lane_data(size_q, wdata_q) & merge_mask);
                        state_d = ST_WRITE;
                    end else begin
                        rdata_d = load_extend(size_q, sgn_q, addr_q[1:0], bus.mem_rdata);
                        state_d = ST_RESP;
                    end
                end
            end
            ST_WRITE: begin
                if (bus.mem_ack) begin
                    rdata_d = '0;
                    state_d = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            size_q  <= '0;
            sgn_q   <= 1'b0;
            addr_q  <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            wdata_q <= '0;
`ifdef LSU_BYTE_EN
            be_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            sgn_q   <= sgn_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            wdata_q <= wdata_d;
`ifdef LSU_BYTE_EN
            be_q    <= be_d;
`endif
        end
    end

    // mem_req is decoded from state so an async reset drops it immediately.
    assign bus.req_ready  = (state_q == ST_IDLE);
    assign bus.resp_valid = (state_q == ST_RESP);
    assign bus.resp_err   = (state_q == ST_RESP) & err_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.mem_req    = (state_q == ST_READ) | (state_q == ST_WRITE);
    assign bus.mem_we     = (state_q == ST_WRITE);
    assign bus.mem_addr   = addr_q[ADDR_W-1:2];
    assign bus.mem_wdata  = wdata_q;
`ifdef LSU_BYTE_EN
    assign bus.mem_be     = be_q;
`endif
endmodule

// File: tb/tb_lsu_mem_master.sv
// Scoreboard bench for lsu_mem_master: directed cases plus randomized loads/stores against a byte-array model.
module tb_lsu_mem_master;
    localparam int ADDR_W = 12;
    localparam int NWORDS = 1 << (ADDR_W - 2);

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    typedef struct {
        logic [ADDR_W-3:0] addr;
        logic [31:0]       data;
        logic [3:0]        be;
    } wr_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lsu_mem_master_if #(.ADDR_W(ADDR_W)) bus ();
    lsu_mem_master #(.ADDR_W(ADDR_W)) dut (.clk(clk), .reset(reset), .bus(bus));

    exp_t        exp_q[$];
    wr_t         wr_log[$];
    logic [31:0] mem   [NWORDS];
    logic [7:0]  ref_b [4*NWORDS];

    int checks = 0, errors = 0;
    int cyc = 0, acc_cyc = 0, resp_cyc = 0, resp_cnt = 0, rd_cnt = 0, req_cyc = 0;
    logic [31:0] last_rdata = '0;
    logic        last_err = 1'b0;
    logic        prev_rv = 1'b0;

    bit          auto_resp = 1'b1, rand_wait = 1'b0;
    int          fixed_wait = 0, wcnt = 0;
    logic        man_ack = 1'b0;
    logic [31:0] man_rdata = '0;

    logic              preq = 1'b0, pack = 1'b0, pwe = 1'b0;
    logic [ADDR_W-3:0] paddr = '0;
    logic [31:0]       pwd = '0;
    logic [3:0]        cur_be;

`ifdef LSU_BYTE_EN
    assign cur_be = bus.mem_be;
`else
    assign cur_be = 4'b1111;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, want);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired or unexpected event, required none", name);
    endtask

    task automatic set_word(input int w, input logic [31:0] v);
        mem[w] = v;
        for (int k = 0; k < 4; k++) ref_b[4*w+k] = v[8*k +: 8];
    endtask

    // Reference: byte-addressed memory, size in bytes, alignment by modulo.
    task automatic model(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [ADDR_W-1:0] addr, input logic [31:0] wd, output exp_t e);
        int n, a;
        logic [31:0] v;
        n = (size == 2'd0) ? 4 : (size == 2'd1) ? 1 : (size == 2'd2) ? 2 : 0;
        a = int'(addr);
        e.rdata = '0;
        if (n == 0) e.err = 1'b1;
        else        e.err = (a % n) != 0;
        if (!e.err) begin
            if (we) begin
                for (int k = 0; k < n; k++) ref_b[a+k] = wd[8*k +: 8];
            end else begin
                v = '0;
                for (int k = 0; k < n; k++) v[8*k +: 8] = ref_b[a+k];
                if (sgn && n < 4 && v[8*n-1]) for (int b = 8*n; b < 32; b++) v[b] = 1'b1;
                e.rdata = v;
            end
        end
    endtask

    function automatic int next_wait();
        return rand_wait ? int'($urandom_range(0, 2)) : fixed_wait;
    endfunction

    initial begin : responder
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!auto_resp) begin
                bus.mem_ack   = man_ack;
                bus.mem_rdata = man_rdata;
            end else if (bus.mem_req && wcnt == 0) begin
                bus.mem_ack = 1'b1;
                if (bus.mem_we) begin
                    for (int k = 0; k < 4; k++)
                        if (cur_be[k]) mem[bus.mem_addr][8*k +: 8] = bus.mem_wdata[8*k +: 8];
                end else begin
                    bus.mem_rdata = mem[bus.mem_addr];
                end
                wcnt = next_wait();
            end else begin
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = $urandom;
                if (bus.mem_req) wcnt--;
                else             wcnt = next_wait();
            end
        end
    end

    initial begin : mem_mon
        wr_t w;
        forever begin
            @(negedge clk);
            if (bus.mem_req) begin
                req_cyc++;
                chk("ready_low_during_mem", 32'(bus.req_ready), 32'd0);
                if (preq && !pack) begin
                    chk("mem_addr_stable", 32'(bus.mem_addr), 32'(paddr));
                    chk("mem_we_stable", 32'(bus.mem_we), 32'(pwe));
                    chk("mem_wdata_stable", bus.mem_wdata, pwd);
                end
                if (bus.mem_ack) begin
                    if (bus.mem_we) begin
                        w.addr = bus.mem_addr;
                        w.data = bus.mem_wdata;
                        w.be   = cur_be;
                        wr_log.push_back(w);
                    end else begin
                        rd_cnt++;
                    end
                end
            end
            preq  = bus.mem_req;
            pack  = bus.mem_ack;
            pwe   = bus.mem_we;
            paddr = bus.mem_addr;
            pwd   = bus.mem_wdata;
        end
    end

    initial begin : resp_mon
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.resp_valid) begin
                chk("resp_single_cycle", 32'(prev_rv), 32'd0);
                resp_cnt++;
                resp_cyc   = cyc;
                last_rdata = bus.resp_rdata;
                last_err   = bus.resp_err;
                if (exp_q.size() == 0) begin
                    fail("resp_unexpected");
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_rdata", bus.resp_rdata, e.rdata);
                    chk("resp_err", 32'(bus.resp_err), 32'(e.err));
                end
            end
            prev_rv = bus.resp_valid;
        end
    end

    task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [ADDR_W-1:0] addr, input logic [31:0] wd, input bit track);
        int n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            fail("issue_ready_timeout");
            return;
        end
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_size   = size;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        if (track) begin
            model(we, size, sgn, addr, wd, e);
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        acc_cyc        = cyc;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'($urandom_range(0, 1));
        bus.req_size   = 2'($urandom_range(0, 3));
        bus.req_signed = 1'($urandom_range(0, 1));
        bus.req_addr   = ADDR_W'($urandom);
        bus.req_wdata  = $urandom;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((exp_q.size() != 0 || !bus.req_ready) && n < 300);
        if (exp_q.size() != 0 || !bus.req_ready) begin
            fail("wait_idle_timeout");
            exp_q.delete();
        end
    endtask

    task automatic check_one_write(input string name, input logic [ADDR_W-3:0] addr,
                                   input logic [31:0] data, input logic [3:0] be);
        wr_t w;
        chk({name, "_nwrites"}, 32'(wr_log.size()), 32'd1);
        if (wr_log.size() > 0) begin
            w = wr_log.pop_front();
            chk({name, "_addr"}, 32'(w.addr), 32'(addr));
            chk({name, "_wdata"}, w.data, data);
            chk({name, "_be"}, 32'(w.be), 32'(be));
        end
        wr_log.delete();
    endtask

    task automatic chk_lat(input string name, input int want);
        chk(name, 32'(resp_cyc - acc_cyc + 1), 32'(want));
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "simulation time limit");
    end

    initial begin : main
        int r0, q0, n;
        logic [1:0] sz;
        logic [ADDR_W-1:0] ad;
        logic [31:0] rw;

        reset          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_size   = '0;
        bus.req_signed = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        for (int w = 0; w < NWORDS; w++) set_word(w, $urandom);

        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
        chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
`ifdef LSU_BYTE_EN
        chk("rst_mem_be", 32'(bus.mem_be), 32'd0);
`endif
        reset = 1'b1;
        @(negedge clk);

        wr_log.delete();
        issue(1'b1, 2'd0, 1'b0, 12'h010, 32'hDEADBEEF, 1'b1);
        wait_idle();
        check_one_write("st_word", 10'h004, 32'hDEADBEEF, 4'b1111);
        chk_lat("lat_word_store", 2);
        issue(1'b0, 2'd0, 1'b0, 12'h010, 32'h0, 1'b1);
        wait_idle();
        chk("ld_word_rdata", last_rdata, 32'hDEADBEEF);
        chk("ld_word_err", 32'(last_err), 32'd0);
        chk_lat("lat_load", 2);

        set_word(4, 32'h11223344);
        wr_log.delete();
        r0 = rd_cnt;
        issue(1'b1, 2'd1, 1'b0, 12'h012, 32'h000000AA, 1'b1);
        wait_idle();
`ifdef LSU_BYTE_EN
        check_one_write("st_byte_be", 10'h004, 32'hAAAAAAAA, 4'b0100);
        chk("st_byte_reads", 32'(rd_cnt - r0), 32'd0);
        chk_lat("lat_byte_store", 2);
`else
        check_one_write("st_byte_rmw", 10'h004, 32'h11AA3344, 4'b1111);
        chk("st_byte_reads", 32'(rd_cnt - r0), 32'd1);
        chk_lat("lat_rmw", 3);
`endif
        issue(1'b0, 2'd0, 1'b0, 12'h010, 32'h0, 1'b1);
        wait_idle();
        chk("ld_after_byte", last_rdata, 32'h11AA3344);

        set_word(0, 32'h80F07F01);
        issue(1'b0, 2'd1, 1'b1, 12'h003, 32'h0, 1'b1);
        wait_idle();
        chk("lb_003", last_rdata, 32'hFFFFFF80);
        issue(1'b0, 2'd1, 1'b0, 12'h003, 32'h0, 1'b1);
        wait_idle();
        chk("lbu_003", last_rdata, 32'h00000080);
        issue(1'b0, 2'd2, 1'b1, 12'h002, 32'h0, 1'b1);
        wait_idle();
        chk("lh_002", last_rdata, 32'hFFFF80F0);
        issue(1'b0, 2'd2, 1'b0, 12'h000, 32'h0, 1'b1);
        wait_idle();
        chk("lhu_000", last_rdata, 32'h00007F01);

        q0 = req_cyc;
        issue(1'b0, 2'd0, 1'b0, 12'h006, 32'h0, 1'b1);
        wait_idle();
        chk("mis_ld_err", 32'(last_err), 32'd1);
        chk("mis_ld_rdata", last_rdata, 32'd0);
        chk_lat("lat_mis_ld", 1);
        issue(1'b1, 2'd2, 1'b0, 12'h001, 32'h1234, 1'b1);
        wait_idle();
        chk("mis_st_err", 32'(last_err), 32'd1);
        chk_lat("lat_mis_st", 1);
        chk("mis_no_mem_req", 32'(req_cyc - q0), 32'd0);

        fixed_wait = 3;
        issue(1'b0, 2'd0, 1'b0, 12'h010, 32'h0, 1'b1);
        wait_idle();
        chk_lat("lat_wait3", 5);
        chk("wait3_rdata", last_rdata, 32'h11AA3344);
        fixed_wait = 0;

        // Reset while the write beat is outstanding; the late ack must not complete anything.
        auto_resp = 1'b0;
        man_ack   = 1'b0;
        man_rdata = 32'h5555_5555;
        r0 = resp_cnt;
        wr_log.delete();
        issue(1'b1, 2'd1, 1'b0, 12'h020, 32'h00000077, 1'b0);
        @(negedge clk);
        if (bus.mem_req && !bus.mem_we) begin
            man_ack = 1'b1;
            @(negedge clk);
            man_ack = 1'b0;
        end
        n = 0;
        while (!(bus.mem_req && bus.mem_we) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid_in_write", 32'(bus.mem_req && bus.mem_we), 32'd1);
        reset = 1'b0;
        #1;
        chk("rst_mid_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_mid_mem_we", 32'(bus.mem_we), 32'd0);
        @(negedge clk);
        reset   = 1'b1;
        man_ack = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_mid_late_ack_req", 32'(bus.mem_req), 32'd0);
        chk("rst_mid_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_mid_no_resp", 32'(resp_cnt - r0), 32'd0);
        chk("rst_mid_no_write", 32'(wr_log.size()), 32'd0);
        man_ack   = 1'b0;
        auto_resp = 1'b1;
        @(negedge clk);

        rand_wait = 1'b1;
        for (int i = 0; i < 300; i++) begin
            rw = $urandom_range(0, 9);
            sz = (rw < 3) ? 2'd0 : (rw < 6) ? 2'd1 : (rw < 9) ? 2'd2 : 2'd3;
            if ($urandom_range(0, 7) == 0) ad = ADDR_W'(12'hF80 + $urandom_range(0, 127));
            else                           ad = ADDR_W'($urandom_range(0, 127));
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), ad, $urandom, 1'b1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_idle();

        for (int w = 0; w < NWORDS; w++)
            chk("mem_word", mem[w], {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
